// File: rtl/conv11_mac.sv
// 1x1-convolution multiply-accumulate stage: IN_CH signed pairs plus bias -> one result with valid/ready.
// Optional ReLU on the result when CONV11_MAC_RELU_EN is defined.
module conv11_mac #(
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int OUT_WIDTH    = 32,
   parameter int IN_CH        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [OUT_WIDTH-1:0]  bias_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [WEIGHT_WIDTH-1:0] weight_in,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [OUT_WIDTH-1:0]  data_out,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_WIDTH = (IN_CH > 1) ? $clog2(IN_CH) : 1;
   localparam int PW        = DATA_WIDTH + WEIGHT_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(IN_CH - 1);

   typedef enum logic [1:0] {IDLE, ACC, BIAS, HOLD} state_t;

   state_t                 state_q, state_d;
   logic [OUT_WIDTH-1:0]   acc_q, acc_d;
   logic [OUT_WIDTH-1:0]   bias_q, bias_d;
   logic [OUT_WIDTH-1:0]   dout_q, dout_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   vout_q, vout_d;
   logic                   done_q, done_d;

   logic signed [PW-1:0]        prod;
   logic signed [OUT_WIDTH-1:0] prod_ext;
   logic [OUT_WIDTH-1:0]        sum;

   // Operands widened to the full product width so the multiply is exact.
   assign prod     = PW'($signed(data_in)) * PW'($signed(weight_in));
   assign prod_ext = OUT_WIDTH'(prod);
   assign sum      = acc_q + bias_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      bias_d  = bias_q;
      dout_d  = dout_q;
      cnt_d   = cnt_q;
      vout_d  = vout_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            acc_d   = '0;
            cnt_d   = '0;
            bias_d  = bias_in;
            state_d = ACC;
         end
         ACC: if (valid_in) begin
            acc_d = acc_q + OUT_WIDTH'(prod_ext);
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               state_d = BIAS;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BIAS: begin
`ifdef CONV11_MAC_RELU_EN
            dout_d = sum[OUT_WIDTH-1] ? '0 : sum;
`else
            dout_d = sum;
`endif
            vout_d  = 1'b1;
            state_d = HOLD;
         end
         HOLD: if (ready_in) begin
            vout_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         bias_q  <= '0;
         dout_q  <= '0;
         cnt_q   <= '0;
         vout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         bias_q  <= bias_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         vout_q  <= vout_d;
         done_q  <= done_d;
      end
   end

   assign ready_out = (state_q == ACC);
   assign busy      = (state_q != IDLE);
   assign valid_out = vout_q;
   assign data_out  = dout_q;
   assign done      = done_q;

endmodule

// File: tb/tb_conv11_mac.sv
// Directed bench for conv11_mac with IN_CH=4; expected results are hand-computed constants.
module tb_conv11_mac;

   logic        clk = 1'b0;
   logic        rst, start, valid_in, ready_in;
   logic [31:0] bias_in;
   logic [7:0]  data_in, weight_in;
   logic        ready_out, valid_out, busy, done;
   logic [31:0] data_out;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   conv11_mac #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .OUT_WIDTH(32), .IN_CH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .bias_in(bias_in),
      .valid_in(valid_in), .ready_out(ready_out), .data_in(data_in), .weight_in(weight_in),
      .valid_out(valid_out), .ready_in(ready_in), .data_out(data_out),
      .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_acc(input logic [31:0] bias);
      start   = 1'b1;
      bias_in = bias;
      tick();
      start   = 1'b0;
      bias_in = 32'hDEAD_BEEF;
      chk("start_ready", ready_out, 1);
      chk("start_busy", busy, 1);
   endtask

   // Feeds four pairs; with gap set, an idle cycle follows each pair.
   task automatic feed(input logic [3:0][7:0] d, input logic [3:0][7:0] w, input bit gap);
      for (int i = 0; i < 4; i++) begin
         valid_in  = 1'b1;
         data_in   = d[i];
         weight_in = w[i];
         tick();
         if (gap && i < 3) begin
            valid_in  = 1'b0;
            data_in   = 8'h7F;
            weight_in = 8'h7F;
            tick();
            chk("gap_ready", ready_out, 1);
         end
      end
      valid_in = 1'b0;
      chk("last_ready", ready_out, 0);
   endtask

   task automatic get_result(input logic [31:0] exp, input int hold);
      int k;
      ready_in = 1'b0;
      k = 0;
      while (!valid_out && k < 8) begin
         tick();
         k++;
      end
      chk("vout_seen", valid_out, 1);
      chk("result", data_out, exp);
      for (int j = 0; j < hold; j++) begin
         tick();
         chk("hold_vout", valid_out, 1);
         chk("hold_data", data_out, exp);
         chk("hold_done", done, 0);
         chk("hold_ready", ready_out, 0);
      end
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      chk("hs_vout", valid_out, 0);
      chk("hs_done", done, 1);
      chk("hs_busy", busy, 0);
   endtask

   initial begin
      logic [3:0][7:0] d, w;
      rst = 1'b1; start = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
      bias_in = '0; data_in = '0; weight_in = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_vout", valid_out, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", ready_out, 0);
      chk("rst_data", data_out, 0);
      tick();
      chk("idle_ready", ready_out, 0);

      // basic sum with exact latency: 1+2+3+4 + 10 = 20
      ready_in = 1'b1;
      start_acc(32'd10);
      d = {8'd4, 8'd3, 8'd2, 8'd1}; w = {4{8'd1}};
      feed(d, w, 1'b0);
      chk("lat_T_vout", valid_out, 0);
      tick();
      chk("lat_T1_vout", valid_out, 1);
      chk("basic_data", data_out, 32'd20);
      tick();
      chk("lat_T2_vout", valid_out, 0);
      chk("lat_T2_done", done, 1);
      ready_in = 1'b0;
      tick();
      chk("done_once", done, 0);

      // signed extreme: 4 * (-128*127) = -65024
      start_acc(32'd0);
      d = {4{8'h80}}; w = {4{8'h7F}};
      feed(d, w, 1'b0);
`ifdef CONV11_MAC_RELU_EN
      get_result(32'h0000_0000, 0);
`else
      get_result(32'hFFFF_0200, 0);
`endif

      // gaps + backpressure: 3*2 + (-2)*4 + 7*(-1) + 1*5 + 100 = 96
      start_acc(32'd100);
      d = {8'd1, 8'd7, 8'hFE, 8'd3}; w = {8'd5, 8'hFF, 8'd4, 8'd2};
      feed(d, w, 1'b1);
      get_result(32'd96, 5);
      tick();
      chk("bp_done_once", done, 0);

      // ignored start and overrun: 2+3+4+5 + 1 = 15
      start_acc(32'd1);
      d = {4{8'd1}}; w = {8'd5, 8'd4, 8'd3, 8'd2};
      for (int i = 0; i < 4; i++) begin
         valid_in = 1'b1; data_in = d[i]; weight_in = w[i];
         start = (i == 2); bias_in = 32'd999;
         tick();
      end
      data_in = 8'd50; weight_in = 8'd50; start = 1'b1;
      chk("ovr_ready", ready_out, 0);
      tick();
      chk("ovr_vout", valid_out, 1);
      tick();
      valid_in = 1'b0;
      chk("ovr_busy", busy, 1);
      chk("ovr_data", data_out, 32'd15);
      start = 1'b0;
      get_result(32'd15, 1);
      tick();

      // reset mid-ACC, then clean restart: 4 * 10 = 40
      start_acc(32'd7);
      for (int i = 0; i < 2; i++) begin
         valid_in = 1'b1; data_in = 8'd9; weight_in = 8'd9;
         tick();
      end
      valid_in = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_busy", busy, 0);
      chk("mrst_vout", valid_out, 0);
      chk("mrst_done", done, 0);
      chk("mrst_ready", ready_out, 0);
      tick();
      chk("mrst_no_done", done, 0);
      start_acc(32'd0);
      d = {4{8'd5}}; w = {4{8'd2}};
      feed(d, w, 1'b0);
      get_result(32'd40, 0);
      tick();

      // back-to-back: 1+2+3+4 + 3 = 13, then start in done cycle: 4*6 - 3 = 21
      start_acc(32'd3);
      d = {8'd4, 8'd3, 8'd2, 8'd1}; w = {4{8'd1}};
      feed(d, w, 1'b0);
      get_result(32'd13, 0);
      start_acc(32'hFFFF_FFFD);
      d = {4{8'd2}}; w = {4{8'd3}};
      feed(d, w, 1'b0);
      get_result(32'd21, 0);
      tick();
      chk("end_done", done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/conv11_mac.md
Name: conv11_mac

Overview:
1x1-convolution accumulate stage that sits directly upstream of the conv11 output buffer and feeds its data/valid handshake. Per output pixel it consumes IN_CH (activation, weight) pairs, multiply-accumulates them as signed values, and adds a bias. It then presents one OUT_WIDTH result with valid/ready handshake and a one-cycle done pulse.

Parameters:
DATA_WIDTH, 8, signed activation width
WEIGHT_WIDTH, 8, signed weight width
OUT_WIDTH, 32, signed accumulator/result width; must be >= DATA_WIDTH+WEIGHT_WIDTH+clog2(IN_CH)
IN_CH, 16, input channels accumulated per result; must be >= 1
CNT_WIDTH, derived localparam = max(1, clog2(IN_CH)); channel counter width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  begin one accumulation; sampled only in IDLE
bias_in  input  OUT_WIDTH  signed bias, sampled on accepted start
valid_in  input  1  data_in/weight_in valid
ready_out  output  1  stage can accept a pair this cycle
data_in  input  DATA_WIDTH  signed activation
weight_in  input  WEIGHT_WIDTH  signed weight
valid_out  output  1  data_out valid
ready_in  input  1  downstream accepts data_out
data_out  output  OUT_WIDTH  signed result
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on the output handshake

Behaviour:
- Reset, synchronous: when rst is high at a clock edge, state=IDLE; acc, cnt, bias_reg and data_out are 0; valid_out=0; done=0. rst takes priority over every other input.
- ready_out is combinational and equals (state==ACC). valid_out and data_out are registered. done is registered and equals 1 for exactly the cycle after the output handshake.
- IDLE: if start=1, then acc<=0, cnt<=0, bias_reg<=bias_in, and go to ACC. valid_in is ignored in IDLE.
- ACC: on each cycle with valid_in=1, acc <= acc + sext(data_in*weight_in). The product is a full signed DATA_WIDTH+WEIGHT_WIDTH result, sign-extended to OUT_WIDTH. cnt increments on each accepted pair.
  - Gaps (valid_in=0) hold acc and cnt.
  - When a pair is accepted with cnt==IN_CH-1, go to BIAS. Pairs arriving after that are not accepted, because ready_out=0.
- BIAS, one cycle: data_out <= acc + bias_reg, wrapping modulo 2^OUT_WIDTH. valid_out<=1; go to HOLD.
- HOLD: valid_out stays 1 and data_out stays stable until ready_in=1.
  - On the cycle valid_out&&ready_in: next cycle valid_out=0, done=1, state=IDLE.
  - ready_in may be high on the first HOLD cycle; this gives a single-cycle transfer.
- Latency: the last pair is accepted at edge T; valid_out rises after edge T+1; the earliest done is after edge T+2. Throughput is 1 pair/cycle, plus 2 overhead cycles and the handshake per result.
- start is ignored in every state other than IDLE. A start in the same cycle as the done pulse, where state is already IDLE, is accepted.
- If IN_CH==1, the first accepted pair moves directly to BIAS.
- Reset mid-operation, in ACC/BIAS/HOLD: the partial sum is discarded, no done pulse is issued, and valid_out drops the next cycle.
- Overflow is not detected; accumulation wraps silently at OUT_WIDTH bits.

Optional Feature:
Macro CONV11_MAC_RELU_EN.
- Defined: in BIAS, if the signed sum acc+bias_reg is negative, data_out <= 0; otherwise data_out <= the sum. This applies a ReLU before the output stage.
- Undefined: data_out is the raw signed sum. Latency and handshake are identical either way.

Test Plan:
- Basic sum. IN_CH=4, bias=10, data=1,2,3,4, weights=1 each, back-to-back, ready_in=1 -> valid_out 1 cycle with data_out=20, done pulse the next cycle, and exactly 2 cycles from last pair to valid_out.
- Signed extreme. IN_CH=4, bias=0, data=-128 x4, weight=127 x4.
  - Macro undefined -> data_out=0xFFFF0200 (-65024).
  - Macro defined -> data_out=0.
- Backpressure and gaps. IN_CH=4, valid_in toggles 1,0,1,0,..., then ready_in is held low for 5 HOLD cycles -> ready_out is high only in ACC, acc is unchanged on gaps, valid_out/data_out are stable for 5 cycles, and done pulses once, the cycle after ready_in rises.
- Ignored start and overrun. Pulse start during ACC and HOLD, and hold valid_in=1 for 2 extra cycles after the 4th pair -> no restart, extra pairs not accepted, and the result uses only the first 4 pairs.
- Reset mid-ACC. After 2 of 4 pairs, assert rst for 1 cycle -> next cycle state IDLE, valid_out=0, done=0, busy=0. A new start with data=5 x4, weight=2, bias=0 -> data_out=40, with no residue from the aborted sum.
- Back-to-back results. Assert start in the done-pulse cycle -> the second accumulation starts immediately, the bias is resampled, and both results are correct.
